// File: rtl/pio_pkg.sv
// Shared definitions for the PIO input/interrupt block: register word
// addresses and the legal ranges of the block parameters.
package pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd4;

    localparam int WIDTH_MIN       = 1;
    localparam int WIDTH_MAX       = 32;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int DEBOUNCE_MIN    = 0;
    localparam int DEBOUNCE_MAX    = 65535;

endpackage

// File: rtl/pio_debounce.sv
// One input channel: synchroniser chain followed by an optional debounce
// filter whose output only follows after a run of stable samples.
module pio_debounce
    import pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic filt
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    logic                   filt_r;

    // Synchroniser chain; the last stage is the first safe sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_s = sync_r[SYNC_STAGES-1];

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        // Filter bypassed: one register stage only.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                filt_r <= 1'b0;
            end else begin
                filt_r <= sync_s;
            end
        end
    end else begin : g_debounce
        localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
        localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

        logic [CNT_W-1:0] cnt_r;

        // Count consecutive disagreeing samples; the Nth one commits the new value.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_r  <= {CNT_W{1'b0}};
                filt_r <= 1'b0;
            end else if (sync_s == filt_r) begin
                cnt_r  <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                cnt_r  <= {CNT_W{1'b0}};
                filt_r <= sync_s;
            end else if (cnt_r != CNT_MAX) begin
                cnt_r  <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r  <= cnt_r;
            end
        end
    end

    assign filt = filt_r;

endmodule

// File: rtl/pio_input_irq.sv
// Avalon-MM PIO input port with per-channel synchronise/debounce, edge
// capture with rise/fall enables, and a masked level interrupt.
module pio_input_irq
    import pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] filt_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] set_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] rise_en_r;
    logic [WIDTH-1:0] fall_en_r;
    logic [WIDTH-1:0] cap_r;
    logic [WIDTH-1:0] mask_r;
    logic [31:0]      rdmux_s;
    logic [31:0]      readdata_r;
    logic             wr_s;
    logic             irq_r;
    logic             unused_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        pio_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (in_port[i]),
            .filt   (filt_s[i])
        );
    end

    // Upper write-data bits have no destination when WIDTH < 32.
    assign unused_s = ^writedata;

    // Edge detection, bus decode and read multiplexer.
    always_comb begin
        wr_s   = chipselect & ~write_n;
        rise_s = filt_s & ~prev_r;
        fall_s = ~filt_s & prev_r;
        set_s  = (rise_s & rise_en_r) | (fall_s & fall_en_r);
        if (wr_s && (address == ADDR_EDGE_CAP)) begin
            clr_s = writedata[WIDTH-1:0];
        end else begin
            clr_s = {WIDTH{1'b0}};
        end
        rdmux_s = 32'd0;
        case (address)
            ADDR_DATA:     rdmux_s[WIDTH-1:0] = filt_s;
            ADDR_RISE_EN:  rdmux_s[WIDTH-1:0] = rise_en_r;
            ADDR_FALL_EN:  rdmux_s[WIDTH-1:0] = fall_en_r;
            ADDR_EDGE_CAP: rdmux_s[WIDTH-1:0] = cap_r;
            ADDR_IRQ_MASK: rdmux_s[WIDTH-1:0] = mask_r;
            default:       rdmux_s = 32'd0;
        endcase
    end

    // Control registers and edge capture; a new edge outranks a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_r    <= {WIDTH{1'b0}};
            rise_en_r <= {WIDTH{1'b0}};
            fall_en_r <= {WIDTH{1'b0}};
            cap_r     <= {WIDTH{1'b0}};
            mask_r    <= {WIDTH{1'b0}};
        end else begin
            prev_r <= filt_s;
            cap_r  <= (cap_r & ~clr_s) | set_s;
            if (wr_s) begin
                case (address)
                    ADDR_RISE_EN:  rise_en_r <= writedata[WIDTH-1:0];
                    ADDR_FALL_EN:  fall_en_r <= writedata[WIDTH-1:0];
                    ADDR_IRQ_MASK: mask_r    <= writedata[WIDTH-1:0];
                    default: begin
                        rise_en_r <= rise_en_r;
                        fall_en_r <= fall_en_r;
                        mask_r    <= mask_r;
                    end
                endcase
            end
        end
    end

    // Registered bus-facing outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 32'd0;
            irq_r      <= 1'b0;
        end else begin
            readdata_r <= rdmux_s;
            irq_r      <= |(cap_r & mask_r);
        end
    end

    assign readdata = readdata_r;
    assign irq      = irq_r;

endmodule

// File: tb/tb_pio_input_irq.sv
// Bench for pio_input_irq: a bypass instance and a 4-cycle debounce instance
// share one bus and input, checked every cycle against a reference model.
module tb_pio_input_irq;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int DB = 4;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [W-1:0] in_port;
    logic [31:0] rd0, rd1;
    logic        irq0, irq1;

    int n_total = 0;
    int n_bad   = 0;

    pio_input_irq #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .in_port(in_port), .irq(irq0)
    );

    pio_input_irq #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DB)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1),
        .in_port(in_port), .irq(irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: index 0 = bypass instance, index 1 = debounced instance.
    logic [7:0]  m_pipe [S];
    logic [7:0]  m_sh [$];
    logic [7:0]  m_rise, m_fall, m_mask;
    logic [7:0]  m_filt [2];
    logic [7:0]  m_prev [2];
    logic [7:0]  m_cap  [2];
    logic [31:0] m_rd   [2];
    logic        m_irq  [2];

    function automatic logic [31:0] reg_view(input logic [2:0] a, input int d);
        case (a)
            3'd0:    return {24'h0, m_filt[d]};
            3'd1:    return {24'h0, m_rise};
            3'd2:    return {24'h0, m_fall};
            3'd3:    return {24'h0, m_cap[d]};
            3'd4:    return {24'h0, m_mask};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [7:0] edges_seen(input int d);
        return (m_filt[d] & ~m_prev[d] & m_rise) | (~m_filt[d] & m_prev[d] & m_fall);
    endfunction

    always @(posedge clk or negedge reset_n) begin : ref_model
        logic [7:0] sync_v, clr_v, flip_v;
        logic       wr_v;
        if (!reset_n) begin
            for (int j = 0; j < S; j++) m_pipe[j] <= 8'h00;
            m_sh.delete();
            m_rise <= 8'h00;
            m_fall <= 8'h00;
            m_mask <= 8'h00;
            for (int d = 0; d < 2; d++) begin
                m_filt[d] <= 8'h00;
                m_prev[d] <= 8'h00;
                m_cap[d]  <= 8'h00;
                m_rd[d]   <= 32'h0;
                m_irq[d]  <= 1'b0;
            end
        end else begin
            wr_v   = chipselect && !write_n;
            clr_v  = (wr_v && address == 3'd3) ? writedata[7:0] : 8'h00;
            sync_v = m_pipe[S-1];
            // Debounced value flips where the last DB samples all disagree with it.
            m_sh.push_back(sync_v);
            if (m_sh.size() > DB) void'(m_sh.pop_front());
            flip_v = 8'h00;
            if (m_sh.size() == DB) begin
                flip_v = 8'hFF;
                foreach (m_sh[j]) flip_v = flip_v & (m_sh[j] ^ m_filt[1]);
            end
            for (int d = 0; d < 2; d++) begin
                m_rd[d]   <= reg_view(address, d);
                m_irq[d]  <= |(m_cap[d] & m_mask);
                m_cap[d]  <= (m_cap[d] & ~clr_v) | edges_seen(d);
                m_prev[d] <= m_filt[d];
            end
            m_filt[0] <= sync_v;
            m_filt[1] <= m_filt[1] ^ flip_v;
            m_pipe[0] <= in_port;
            for (int j = 1; j < S; j++) m_pipe[j] <= m_pipe[j-1];
            if (wr_v) begin
                case (address)
                    3'd1:    m_rise <= writedata[7:0];
                    3'd2:    m_fall <= writedata[7:0];
                    3'd4:    m_mask <= writedata[7:0];
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        check_eq("mon_rd0",  rd0,  m_rd[0]);
        check_eq("mon_irq0", {31'h0, irq0}, {31'h0, m_irq[0]});
        check_eq("mon_rd1",  rd1,  m_rd[1]);
        check_eq("mon_irq1", {31'h0, irq1}, {31'h0, m_irq[1]});
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cyc(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [2:0] a);
        address = a;
        cyc(1);
    endtask

    task automatic async_reset_check(input string tag);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq({tag, "_rd0"},  rd0, 32'h0);
        check_eq({tag, "_irq0"}, {31'h0, irq0}, 32'h0);
        check_eq({tag, "_rd1"},  rd1, 32'h0);
        check_eq({tag, "_irq1"}, {31'h0, irq1}, 32'h0);
        cyc(2);
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'h00;
        cyc(3);
        check_eq("rst_rd0",  rd0, 32'h0);
        check_eq("rst_irq0", {31'h0, irq0}, 32'h0);
        reset_n = 1'b1;
        cyc(2);

        // Enabled rise on bit 0 raises irq within SYNC_STAGES+3 cycles.
        bus_wr(3'd1, 32'h01);
        bus_wr(3'd4, 32'h01);
        in_port = 8'h01;
        for (int k = 0; k < S + 3; k++) begin
            cyc(1);
            if (irq0) break;
        end
        check_eq("rise_irq", {31'h0, irq0}, 32'h1);
        bus_rd(3'd3);
        check_eq("rise_cap", rd0, 32'h01);

        // Clear write in the same cycle as a fresh rise: the bit stays set.
        in_port = 8'h00;
        cyc(8);
        in_port = 8'h01;
        cyc(3);
        bus_wr(3'd3, 32'h01);
        check_eq("collide_irq_a", {31'h0, irq0}, 32'h1);
        cyc(1);
        check_eq("collide_cap", rd0, 32'h01);
        check_eq("collide_irq_b", {31'h0, irq0}, 32'h1);

        // Debounce: a 3-cycle pulse is rejected, a 4-cycle one passes.
        address = 3'd0;
        in_port = 8'h05;
        cyc(3);
        in_port = 8'h01;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            if (rd1[2]) seen = 1'b1;
        end
        check_eq("db_short", {31'h0, seen}, 32'h0);
        in_port = 8'h05;
        cyc(4);
        in_port = 8'h01;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            if (rd1[2]) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("db_long", {31'h0, seen}, 32'h1);

        // Masked fall capture, then unmasking raises irq one cycle later.
        in_port = 8'h81;
        cyc(10);
        bus_wr(3'd4, 32'h00);
        bus_wr(3'd3, 32'hFF);
        bus_wr(3'd2, 32'h80);
        in_port = 8'h01;
        cyc(10);
        bus_rd(3'd3);
        check_eq("fall_cap0", rd0, 32'h80);
        check_eq("fall_cap1", rd1, 32'h80);
        check_eq("fall_masked", {31'h0, irq0}, 32'h0);
        bus_wr(3'd4, 32'h80);
        check_eq("unmask_pre", {31'h0, irq0}, 32'h0);
        cyc(1);
        check_eq("unmask_irq0", {31'h0, irq0}, 32'h1);
        check_eq("unmask_irq1", {31'h0, irq1}, 32'h1);

        // Reserved addresses read zero; DATA reflects the filtered inputs.
        in_port = 8'hFF;
        cyc(10);
        for (int a = 5; a < 8; a++) begin
            bus_rd(3'(a));
            check_eq("rsvd_rd", rd0, 32'h0);
        end
        bus_rd(3'd0);
        check_eq("data_rd0", rd0, 32'hFF);
        check_eq("data_rd1", rd1, 32'hFF);

        // All bits captured and interrupting, then asynchronous reset.
        bus_wr(3'd1, 32'hFF);
        bus_wr(3'd2, 32'hFF);
        bus_wr(3'd4, 32'hFF);
        in_port = 8'h00;
        cyc(10);
        bus_rd(3'd3);
        check_eq("full_cap", rd0, 32'hFF);
        check_eq("full_irq", {31'h0, irq0}, 32'h1);
        async_reset_check("arst");
        for (int a = 1; a < 5; a++) begin
            bus_rd(3'(a));
            check_eq("post_rst_reg", rd0, 32'h0);
        end

        // Randomised traffic with one mid-run reset.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) in_port = in_port ^ (8'd1 << $urandom_range(0, 7));
            address    = 3'($urandom_range(0, 7));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) != 0);
            writedata  = $urandom;
            if (i == 1000) async_reset_check("rand_rst");
            cyc(1);
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        cyc(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pio_input_irq.md
PIO_INPUT_IRQ -- requirements
Module: pio_input_irq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of input channels, legal 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser flops per channel, legal 2..4.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 0: cycles of stability before the filtered value follows, legal 0..65535; 0 = bypass.
REQ-004 SHALL have port clk  in  1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  in  1: reset, asynchronous and active-low.
REQ-006 SHALL have port address  in  3: Avalon-MM word address.
REQ-007 SHALL have port chipselect  in  1: slave select.
REQ-008 SHALL have port write_n  in  1: write strobe, active-low, qualified by chipselect.
REQ-009 SHALL have port writedata  in  32: write data.
REQ-010 SHALL have port readdata  out  32: registered read data.
REQ-011 SHALL have port in_port  in  WIDTH: asynchronous input channels.
REQ-012 SHALL have port irq  out  1: level interrupt, active-high, registered.

Function
REQ-013 SHALL pass each in_port bit through SYNC_STAGES flops; the last stage is sync[i].
REQ-014 With DEBOUNCE_CYCLES=0, filt[i] SHALL equal sync[i] registered once.
REQ-015 With DEBOUNCE_CYCLES=N>0, filt[i] SHALL take sync[i] only after sync[i] differs from filt[i] for N consecutive cycles; any reversion to filt[i] restarts the per-channel counter at 0.
REQ-016 Debounce counter width SHALL be clog2(N+1); the counter SHALL saturate and never wrap.
REQ-017 SHALL keep prev[i] = filt[i] delayed one cycle; rise[i] = filt & ~prev; fall[i] = ~filt & prev.
REQ-018 Register map (word addresses): 0 DATA RO = filt; 1 RISE_EN RW; 2 FALL_EN RW; 3 EDGE_CAP W1C; 4 IRQ_MASK RW; 5-7 read 0, writes ignored.
REQ-019 A write SHALL occur when chipselect=1 and write_n=0; RW registers SHALL store writedata[WIDTH-1:0].
REQ-020 EDGE_CAP[i] SHALL set on (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]) and hold until cleared.
REQ-021 A write to EDGE_CAP SHALL clear each bit whose writedata bit is 1; other bits are unaffected.
REQ-022 Same-cycle set and clear on one bit SHALL leave the bit set; no edge is lost.
REQ-023 readdata SHALL update every cycle from the current address, independent of chipselect, giving one cycle of read latency; bits 31:WIDTH SHALL read 0.
REQ-024 irq SHALL be registered as OR of (EDGE_CAP & IRQ_MASK), asserting one cycle after the qualifying EDGE_CAP or IRQ_MASK change.
REQ-025 Changing RISE_EN or FALL_EN SHALL not alter already-captured bits.

Reset
REQ-026 reset_n low SHALL asynchronously clear all synchroniser, filter, prev and counter state, RISE_EN, FALL_EN, EDGE_CAP and IRQ_MASK; readdata and irq SHALL read 0.
REQ-027 After reset release, a high input SHALL appear as a rising edge once it propagates through the synchroniser, and is captured only if RISE_EN is then set.
REQ-028 Reset asserted mid-debounce SHALL discard the partial count.

Structure
REQ-029 Shared package pio_pkg SHALL hold the address constants (ADDR_DATA..ADDR_IRQ_MASK) and the legal parameter limits.
REQ-030 Per-channel synchroniser and debounce logic SHALL be one sub-module, pio_debounce, instantiated WIDTH times via generate.

Verification
REQ-031 WIDTH=8, N=0: write RISE_EN=0x01, IRQ_MASK=0x01, drive in_port 0x00->0x01 -> EDGE_CAP=0x01; irq=1 within SYNC_STAGES+3 cycles.
REQ-032 Write EDGE_CAP=0x01 in the same cycle as a new enabled rise on bit 0 -> EDGE_CAP bit 0 stays 1 and irq stays 1.
REQ-033 N=4: pulse bit 2 high for 3 cycles then low -> DATA bit 2 never 1; held high for 4 cycles -> DATA bit 2 = 1.
REQ-034 FALL_EN=0x80, IRQ_MASK=0x00, drive bit 7 1->0 -> EDGE_CAP=0x80 and irq=0; then write IRQ_MASK=0x80 -> irq=1 one cycle later.
REQ-035 Read addresses 5, 6 and 7, and read DATA with WIDTH=8 and in_port=0xFF -> readdata = 0 for 5-7 and 0x000000FF for DATA.
REQ-036 Assert reset_n mid-operation with EDGE_CAP=0xFF and irq=1 -> all registers, readdata and irq = 0 immediately (asynchronously).
